riscv_mem: RTL and testbench

Single-port word-addressed memory that services the `riscv` core's picorv32-style native memory bus and returns instruction fetches and data loads. It is the core's only slave. It inserts a configurable number of wait states, applies byte-lane write strobes, and flags out-of-range accesses without hanging the core.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/riscv_mem_array.sv | 24 ++
 rtl/riscv_mem.sv | 119 +++++++++++
 tb/tb_riscv_mem.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv core slice: memory-slave FSM states
// and the byte-strobe encodings used by the store path.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_t;

   localparam logic [3:0] WSTRB_NONE = 4'b0000;
   localparam logic [3:0] WSTRB_BYTE = 4'b0001;
   localparam logic [3:0] WSTRB_HALF = 4'b0011;
   localparam logic [3:0] WSTRB_WORD = 4'b1111;

endpackage

// File: rtl/riscv_mem_array.sv
module riscv_mem_array #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter string       INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [3:0]                   we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/riscv_mem.sv
// Native-bus memory slave for the riscv core: wait-state insertion, byte-lane
// writes, sticky out-of-range fault capture and an instruction-fetch counter.
module riscv_mem
   import riscv_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_STATES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        fault,
   output logic [31:0] fault_addr,
   output logic [31:0] fetch_count
);

   localparam int unsigned AW        = $clog2(MEM_WORDS);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   mem_state_t  state;
   logic [3:0]  wait_cnt;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        req_instr;
   logic        rdata_zero;

   logic        access, oor;
   logic [31:0] src_addr, src_wdata, arr_rdata;
   logic [3:0]  src_wstrb;
   logic        src_instr;

   // With zero wait states the array is accessed on the same edge the request
   // is latched, so the live bus is used in IDLE and the latched copy in WAIT.
   always_comb begin
      src_addr  = req_addr;
      src_wdata = req_wdata;
      src_wstrb = req_wstrb;
      src_instr = req_instr;
      if (state == IDLE) begin
         src_addr  = mem_addr;
         src_wdata = mem_wdata;
         src_wstrb = mem_wstrb;
         src_instr = mem_instr;
      end
      oor    = (src_addr[31:AW+2] != '0);
      access = reset && mem_valid &&
               (((state == IDLE) && (WAIT_STATES == 0)) ||
                ((state == WAIT) && (wait_cnt == '0)));
   end

   riscv_mem_array #(
      .MEM_WORDS (MEM_WORDS),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .en    (access),
      .we    (oor ? 4'b0000 : src_wstrb),
      .addr  (src_addr[AW+1:2]),
      .wdata (src_wdata),
      .rdata (arr_rdata)
   );

   // Out-of-range reads and the post-reset value both present as zero
   // without touching the array's own output register.
   assign mem_rdata = rdata_zero ? '0 : arr_rdata;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         mem_ready   <= 1'b0;
         rdata_zero  <= 1'b1;
         fault       <= 1'b0;
         fault_addr  <= '0;
         fetch_count <= '0;
      end else begin
         mem_ready <= access;
         if (access) begin
            rdata_zero <= oor;
            if (oor) begin
               fault <= 1'b1;
               if (!fault) fault_addr <= src_addr;
            end
            if (src_instr) fetch_count <= fetch_count + 32'd1;
         end
         case (state)
            IDLE: begin
               if (mem_valid) begin
                  req_addr  <= mem_addr;
                  req_wdata <= mem_wdata;
                  req_wstrb <= mem_wstrb;
                  req_instr <= mem_instr;
                  if (WAIT_STATES == 0) begin
                     state <= RESP;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (!mem_valid)           state    <= IDLE;
               else if (wait_cnt == '0)  state    <= RESP;
               else                      wait_cnt <= wait_cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mem.sv
// Self-checking bench for riscv_mem: three instances (1, 0 and 3 wait states)
// checked against a word-array reference model with lane-level write rules.
module tb_riscv_mem;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst   [3];
   logic        valid [3];
   logic        instr [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  wstrb [3];
   logic        ready [3];
   logic [31:0] rdata [3];
   logic        fault [3];
   logic [31:0] faddr [3];
   logic [31:0] fcnt  [3];

   int unsigned ws_of [3] = '{1, 0, 3};

   logic [31:0] mdl     [3][64];
   bit          known   [3][64];
   bit          m_fault [3];
   logic [31:0] m_faddr [3];
   logic [31:0] m_fcnt  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_mem #(.MEM_WORDS(1024), .WAIT_STATES(1)) dut_ws1 (
      .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_instr(instr[0]),
      .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
      .mem_ready(ready[0]), .mem_rdata(rdata[0]), .fault(fault[0]),
      .fault_addr(faddr[0]), .fetch_count(fcnt[0]));

   riscv_mem #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut_ws0 (
      .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_instr(instr[1]),
      .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
      .mem_ready(ready[1]), .mem_rdata(rdata[1]), .fault(fault[1]),
      .fault_addr(faddr[1]), .fetch_count(fcnt[1]));

   riscv_mem #(.MEM_WORDS(1024), .WAIT_STATES(3)) dut_ws3 (
      .clk(clk), .reset(rst[2]), .mem_valid(valid[2]), .mem_instr(instr[2]),
      .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
      .mem_ready(ready[2]), .mem_rdata(rdata[2]), .fault(fault[2]),
      .fault_addr(faddr[2]), .fetch_count(fcnt[2]));

   // One bus access on instance d. b2b: the previous access left valid high and
   // this request is presented in its RESP cycle. drop: release valid afterwards.
   task automatic do_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s, input bit ins, input bit b2b, input bit drop);
      int          n, w, exp_n;
      bit          oor, chk;
      logic [31:0] exp_rd;
      if (!b2b) @(negedge clk);
      valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = s; instr[d] = ins;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ready[d] && n < 40);
      exp_n = int'(ws_of[d]) + 1 + (b2b ? 1 : 0);
      checks++;
      if (n != exp_n || !ready[d]) begin
         errors++;
         $display("FAIL latency d%0d addr %h got %0d cycles ready=%b expected %0d", d, a, n, ready[d], exp_n);
      end
      oor    = (a >= 32'h0000_1000);
      w      = int'(a[7:2]);
      chk    = oor || known[d][w];
      exp_rd = oor ? 32'h0 : mdl[d][w];
      if (chk) begin
         checks++;
         if (rdata[d] !== exp_rd) begin
            errors++;
            $display("FAIL rdata d%0d addr %h got %h expected %h", d, a, rdata[d], exp_rd);
         end
      end
      if (!oor) begin
         for (int i = 0; i < 4; i++)
            if (s[i]) mdl[d][w][8*i +: 8] = wd[8*i +: 8];
         if (s == WSTRB_WORD) known[d][w] = 1'b1;
      end else begin
         if (!m_fault[d]) m_faddr[d] = a;
         m_fault[d] = 1'b1;
      end
      if (ins) m_fcnt[d] = m_fcnt[d] + 32'd1;
      checks++;
      if (fault[d] !== m_fault[d] || faddr[d] !== m_faddr[d]) begin
         errors++;
         $display("FAIL fault d%0d got %b/%h expected %b/%h", d, fault[d], faddr[d], m_fault[d], m_faddr[d]);
      end
      checks++;
      if (fcnt[d] !== m_fcnt[d]) begin
         errors++;
         $display("FAIL fetch_count d%0d got %0d expected %0d", d, fcnt[d], m_fcnt[d]);
      end
      if (drop) begin
         valid[d] = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (ready[d] !== 1'b0) begin
            errors++;
            $display("FAIL ready_pulse d%0d got %b expected 0", d, ready[d]);
         end
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b0; valid[d] = 1'b0; instr[d] = 1'b0;
         addr[d] = '0; wdata[d] = '0; wstrb[d] = WSTRB_NONE;
         m_fault[d] = 1'b0; m_faddr[d] = '0; m_fcnt[d] = '0;
         for (int w = 0; w < 64; w++) known[d][w] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ready[d] !== 1'b0 || rdata[d] !== 32'h0 || fault[d] !== 1'b0 ||
             faddr[d] !== 32'h0 || fcnt[d] !== 32'h0) begin
            errors++;
            $display("FAIL reset d%0d got rdy=%b rd=%h f=%b fa=%h fc=%h expected all zero",
                     d, ready[d], rdata[d], fault[d], faddr[d], fcnt[d]);
         end
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst[d] = 1'b1;
   endtask

   task automatic test_basic_read();
      do_access(0, 32'h0, 32'h0000_0013, WSTRB_WORD, 1'b0, 1'b0, 1'b1);
      do_access(0, 32'h0, 32'h0, WSTRB_NONE, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_byte_lanes();
      do_access(0, 32'h10, 32'hAABB_CCDD, WSTRB_WORD, 1'b0, 1'b0, 1'b1);
      do_access(0, 32'h10, 32'h0000_0011, WSTRB_BYTE, 1'b0, 1'b0, 1'b1);
      do_access(0, 32'h12, 32'h0000_2222, WSTRB_HALF, 1'b0, 1'b0, 1'b1);
      do_access(0, 32'h10, 32'h0, WSTRB_NONE, 1'b0, 1'b0, 1'b1);
      checks++;
      if (rdata[0] !== 32'hAABB_2222) begin
         errors++;
         $display("FAIL byte_lanes got %h expected aabb2222", rdata[0]);
      end
   endtask

   task automatic test_zero_wait();
      for (int w = 0; w < 8; w++)
         do_access(1, 32'(w * 4), $urandom, WSTRB_WORD, 1'b0, (w != 0), (w == 7));
      for (int k = 0; k < 10; k++)
         do_access(1, 32'($urandom_range(0, 7) * 4), 32'h0, WSTRB_NONE, 1'($urandom_range(0, 1)),
                   (k != 0), (k == 9));
   endtask

   task automatic test_out_of_range();
      do_access(0, 32'h0000_1000, 32'h0, WSTRB_NONE, 1'b0, 1'b0, 1'b1);
      do_access(0, 32'h0000_2000, 32'hDEAD_BEEF, WSTRB_WORD, 1'b0, 1'b0, 1'b1);
      checks++;
      if (faddr[0] !== 32'h0000_1000 || fault[0] !== 1'b1) begin
         errors++;
         $display("FAIL oor_sticky got %b/%h expected 1/00001000", fault[0], faddr[0]);
      end
      // 0x2000 would alias word 0 if the range check were missing.
      do_access(0, 32'h0, 32'h0, WSTRB_NONE, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_abort();
      int pulses = 0;
      do_access(2, 32'h14, 32'h1234_5678, WSTRB_WORD, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      valid[2] = 1'b1; addr[2] = 32'h14; wdata[2] = 32'hFFFF_FFFF;
      wstrb[2] = WSTRB_WORD; instr[2] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      valid[2] = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ready[2]) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL abort_ready got %0d pulses expected 0", pulses);
      end
      do_access(2, 32'h14, 32'h0, WSTRB_NONE, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_midop();
      do_access(2, 32'h18, 32'hCAFE_F00D, WSTRB_WORD, 1'b1, 1'b0, 1'b1);
      do_access(2, 32'h0000_4000, 32'h0, WSTRB_NONE, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      valid[2] = 1'b1; addr[2] = 32'h18; wdata[2] = 32'h0BAD_0BAD;
      wstrb[2] = WSTRB_WORD; instr[2] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst[2] = 1'b0; valid[2] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ready[2] !== 1'b0 || fault[2] !== 1'b0 || fcnt[2] !== 32'h0 ||
          faddr[2] !== 32'h0 || rdata[2] !== 32'h0) begin
         errors++;
         $display("FAIL reset_midop got rdy=%b f=%b fa=%h fc=%h rd=%h expected all zero",
                  ready[2], fault[2], faddr[2], fcnt[2], rdata[2]);
      end
      m_fault[2] = 1'b0; m_faddr[2] = '0; m_fcnt[2] = '0;
      @(negedge clk);
      rst[2] = 1'b1;
      do_access(2, 32'h18, 32'h0, WSTRB_NONE, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [3:0] strobes [5] = '{WSTRB_NONE, WSTRB_BYTE, WSTRB_HALF, WSTRB_WORD, 4'b0000};
      logic [31:0] a;
      logic [3:0]  s;
      for (int d = 0; d < 3; d++)
         for (int w = 0; w < 64; w++)
            do_access(d, 32'(w * 4), $urandom, WSTRB_WORD, 1'b0, 1'b0, 1'b1);
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 60; k++) begin
            a = {24'h0, 2'b00, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) a = 32'h0000_1000 + 32'($urandom_range(0, 32'hF_FFFF));
            s = strobes[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) s = 4'($urandom_range(0, 15));
            do_access(d, a, $urandom, s, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_byte_lanes();
      test_zero_wait();
      test_out_of_range();
      test_abort();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
